// File: rtl/mctx_pkg.sv
// Shared types and defaults for the multi-context queue scheduler slice.
package mctx_pkg;
  localparam int MCTX_NCTX        = 16;
  localparam int MCTX_WIDTH       = 16;
  localparam int MCTX_CRDW        = 4;
  localparam int MCTX_CREDIT_INIT = 8;
  localparam int WRR_WW           = 4;

  typedef logic [$clog2(MCTX_NCTX)-1:0] ctx_idx_t;
  typedef logic [MCTX_CRDW-1:0]         credit_t;

  // Index width that stays legal for a single-context build.
  function automatic int ctx_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mctx_deq_sched_if.sv
// Queue read port, credit returns and output handshake of the dequeue scheduler.
// wrr_weight exists only when MCTX_SCHED_WRR_EN is defined.
interface mctx_deq_sched_if
  import mctx_pkg::*;
#(
  parameter int NCTX  = MCTX_NCTX,
  parameter int WIDTH = MCTX_WIDTH
);
  localparam int IW = ctx_idx_w(NCTX);

  logic [NCTX-1:0]  ctx_en;
  logic [NCTX-1:0]  q_empty;
  logic             q_get;
  logic [NCTX-1:0]  q_gctx;
  logic [WIDTH-1:0] q_dout;
  logic [NCTX-1:0]  cred_ret;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    out_ctx;
  logic             cred_err;
`ifdef MCTX_SCHED_WRR_EN
  logic [NCTX*WRR_WW-1:0] wrr_weight;

  modport master (
    input  ctx_en, q_empty, q_dout, cred_ret, out_ready, wrr_weight,
    output q_get, q_gctx, out_valid, out_data, out_ctx, cred_err
  );
  modport slave (
    output ctx_en, q_empty, q_dout, cred_ret, out_ready, wrr_weight,
    input  q_get, q_gctx, out_valid, out_data, out_ctx, cred_err
  );
`else
  modport master (
    input  ctx_en, q_empty, q_dout, cred_ret, out_ready,
    output q_get, q_gctx, out_valid, out_data, out_ctx, cred_err
  );
  modport slave (
    output ctx_en, q_empty, q_dout, cred_ret, out_ready,
    input  q_get, q_gctx, out_valid, out_data, out_ctx, cred_err
  );
`endif
endinterface

// File: rtl/mctx_rr_arb.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module mctx_rr_arb
  import mctx_pkg::*;
#(
  parameter int NCTX = MCTX_NCTX,
  parameter int IW   = ctx_idx_w(NCTX)
) (
  input  logic [NCTX-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NCTX-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);
  localparam int DW = 2 * NCTX;

  logic [DW-1:0] dbl, lo, msk;
  logic          found;

  // Upper copy of req covers the wrap; masking the lower copy below ptr
  // makes the lowest set bit the round-robin winner.
  always_comb begin
    dbl     = {req, req};
    lo      = (DW'(1) << ptr) - DW'(1);
    msk     = dbl & ~lo;
    found   = 1'b0;
    gnt_idx = '0;
    for (int j = 0; j < DW; j++) begin
      if (msk[j] && !found) begin
        found   = 1'b1;
        gnt_idx = (j >= NCTX) ? IW'(j - NCTX) : IW'(j);
      end
    end
    gnt = found ? (NCTX'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/mctx_deq_sched.sv
// Credit-gated round-robin dequeue scheduler with a one-entry output register.
// Define MCTX_SCHED_WRR_EN for weighted round-robin bursts.
module mctx_deq_sched
  import mctx_pkg::*;
#(
  parameter int NCTX        = MCTX_NCTX,
  parameter int WIDTH       = MCTX_WIDTH,
  parameter int CRDW        = MCTX_CRDW,
  parameter int CREDIT_INIT = MCTX_CREDIT_INIT
) (
  input logic              clk,
  input logic              rst,
  mctx_deq_sched_if.master bus
);
  localparam int IW = ctx_idx_w(NCTX);

  logic [NCTX-1:0]           elig, gnt, cred_nz, ovf;
  logic [IW-1:0]             win, rr_ptr;
  logic                      issue;
  logic [NCTX-1:0][CRDW-1:0] credit, credit_nxt;
  logic                      out_valid_q;
  logic [WIDTH-1:0]          out_data_q;
  logic [IW-1:0]             out_ctx_q;
  logic                      cred_err_q;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NCTX - 1)) ? '0 : p + 1'b1;
  endfunction

  assign elig  = bus.ctx_en & ~bus.q_empty & cred_nz;
  assign issue = ~rst & (|elig) & (~out_valid_q | bus.out_ready);

  mctx_rr_arb #(.NCTX(NCTX), .IW(IW)) u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (win)
  );

  assign bus.q_get     = issue;
  assign bus.q_gctx    = issue ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ctx   = out_ctx_q;
  assign bus.cred_err  = cred_err_q;

  // Issue and return in the same cycle cancel; an over-return is dropped and flagged.
  always_comb begin
    credit_nxt = credit;
    cred_nz    = '0;
    ovf        = '0;
    for (int i = 0; i < NCTX; i++) begin
      cred_nz[i] = |credit[i];
      if (issue && gnt[i] && !bus.cred_ret[i])
        credit_nxt[i] = credit[i] - 1'b1;
      else if (bus.cred_ret[i] && !(issue && gnt[i])) begin
        if (credit[i] == CRDW'(CREDIT_INIT)) ovf[i] = 1'b1;
        else                                 credit_nxt[i] = credit[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCTX; i++) credit[i] <= CRDW'(CREDIT_INIT);
      cred_err_q <= 1'b0;
    end else begin
      credit     <= credit_nxt;
      cred_err_q <= cred_err_q | (|ovf);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctx_q   <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.q_dout;
      out_ctx_q   <= win;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MCTX_SCHED_WRR_EN
  logic [WRR_WW-1:0] bcnt, wt;
  logic [WRR_WW:0]   bnext;

  // The burst only continues if the winner is the context parked at rr_ptr.
  always_comb begin
    wt = bus.wrr_weight[int'(win)*WRR_WW +: WRR_WW];
    if (wt == '0) wt = WRR_WW'(1);
    bnext = ((win == rr_ptr) ? {1'b0, bcnt} : '0) + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      bcnt   <= '0;
    end else if (issue) begin
      if (bnext >= {1'b0, wt}) begin
        rr_ptr <= ptr_inc(win);
        bcnt   <= '0;
      end else begin
        rr_ptr <= win;
        bcnt   <= bnext[WRR_WW-1:0];
      end
    end else if (bcnt != '0 && !elig[rr_ptr]) begin
      rr_ptr <= ptr_inc(rr_ptr);
      bcnt   <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)        rr_ptr <= '0;
    else if (issue) rr_ptr <= ptr_inc(win);
  end
`endif
endmodule

// File: tb/tb_mctx_deq_sched.sv
// Directed bench for mctx_deq_sched: vector table plus hand-written corner sequences.
module tb_mctx_deq_sched;
  import mctx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mctx_deq_sched_if #(.NCTX(16), .WIDTH(16)) bus ();
  mctx_deq_sched #(.NCTX(16), .WIDTH(16), .CRDW(4), .CREDIT_INIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] en, emp, ret;
    logic        rdy;
    logic [15:0] dout;
    logic        get;
    logic [15:0] gctx;
    logic        vld;
    logic [15:0] data;
    logic [3:0]  ctx;
    logic        err;
  } vec_t;

  vec_t tv[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] en, emp, ret, input logic rdy,
                              input logic [15:0] dout, input logic get,
                              input logic [15:0] gctx, input logic vld,
                              input logic [15:0] data, input logic [3:0] ctx,
                              input logic err);
    vec_t v;
    v.en = en; v.emp = emp; v.ret = ret; v.rdy = rdy; v.dout = dout;
    v.get = get; v.gctx = gctx; v.vld = vld; v.data = data; v.ctx = ctx; v.err = err;
    return v;
  endfunction

  function automatic int oh2i(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 99;
  endfunction

  task automatic setin(input logic [15:0] en, emp, ret, input logic rdy, input logic [15:0] dout);
    bus.ctx_en = en; bus.q_empty = emp; bus.cred_ret = ret;
    bus.out_ready = rdy; bus.q_dout = dout;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    setin(16'hFFFF, 16'hFFFF, 16'h0, 1'b1, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts issues over a fixed window starting at the current negedge.
  task automatic count_issues(input int cycles, input logic [15:0] exp_oh, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (bus.q_get) begin
        cnt++;
        if (bus.q_gctx !== exp_oh) chk("burst_gctx", bus.q_gctx, exp_oh);
      end
      @(negedge clk);
    end
  endtask

  int cnt;
  int order[8];
  int exp_order[8];

  initial begin
    localparam logic [15:0] NE = ~16'h0224;
    setin(16'h0, 16'hFFFF, 16'h0, 1'b1, 16'h0);
`ifdef MCTX_SCHED_WRR_EN
    bus.wrr_weight = '0;
`endif
    do_reset();

    //        en        emp       ret      rdy  dout      get gctx      vld data      ctx err
    tv.push_back(mk(16'hFFFF, 16'hFFFF, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 1, 16'hA001, 1, 16'h0004, 0, 16'h0000, 0, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 1, 16'hA002, 1, 16'h0020, 1, 16'hA001, 2, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 1, 16'hA003, 1, 16'h0200, 1, 16'hA002, 5, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 1, 16'hA004, 1, 16'h0004, 1, 16'hA003, 9, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 0, 16'hA005, 0, 16'h0000, 1, 16'hA004, 2, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 0, 16'hA006, 0, 16'h0000, 1, 16'hA004, 2, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 0, 16'hA007, 0, 16'h0000, 1, 16'hA004, 2, 0));
    tv.push_back(mk(16'hFFFF, NE,       16'h0000, 1, 16'hA008, 1, 16'h0020, 1, 16'hA004, 2, 0));
    tv.push_back(mk(16'hFFFF, 16'hFFFF, 16'h0000, 1, 16'hA009, 0, 16'h0000, 1, 16'hA008, 5, 0));
    tv.push_back(mk(16'hFFFF, 16'hFFFF, 16'h0000, 1, 16'hA00A, 0, 16'h0000, 0, 16'hA008, 5, 0));
    tv.push_back(mk(16'hFFFF, 16'hFDFF, 16'h0000, 0, 16'hB001, 1, 16'h0200, 0, 16'hA008, 5, 0));
    tv.push_back(mk(16'hFFFF, 16'hFDFF, 16'h0000, 0, 16'hB002, 0, 16'h0000, 1, 16'hB001, 9, 0));
    tv.push_back(mk(16'hFFFF, 16'hFDFF, 16'h0000, 0, 16'hB003, 0, 16'h0000, 1, 16'hB001, 9, 0));
    tv.push_back(mk(16'hFFFF, 16'hFDFF, 16'h0000, 1, 16'hB004, 1, 16'h0200, 1, 16'hB001, 9, 0));
    tv.push_back(mk(16'hFFFF, 16'hFFFF, 16'h0000, 1, 16'hB005, 0, 16'h0000, 1, 16'hB004, 9, 0));
    tv.push_back(mk(16'hFFFF, 16'hFFFF, 16'h0000, 1, 16'hB006, 0, 16'h0000, 0, 16'hB004, 9, 0));
    tv.push_back(mk(16'hFFFB, 16'hFFDB, 16'h0000, 1, 16'hC001, 1, 16'h0020, 0, 16'hB004, 9, 0));
    tv.push_back(mk(16'hFFDF, 16'hFFDB, 16'h0000, 1, 16'hC002, 1, 16'h0004, 1, 16'hC001, 5, 0));
    tv.push_back(mk(16'h0000, 16'hFFDB, 16'h0004, 1, 16'hC003, 0, 16'h0000, 1, 16'hC002, 2, 0));
    tv.push_back(mk(16'h0000, 16'hFFDB, 16'h0000, 1, 16'hC004, 0, 16'h0000, 0, 16'hC002, 2, 0));

    foreach (tv[k]) begin
      @(negedge clk);
      setin(tv[k].en, tv[k].emp, tv[k].ret, tv[k].rdy, tv[k].dout);
      #1;
      chk($sformatf("r%0d.get", k),  bus.q_get,     tv[k].get);
      chk($sformatf("r%0d.gctx", k), bus.q_gctx,    tv[k].gctx);
      chk($sformatf("r%0d.vld", k),  bus.out_valid, tv[k].vld);
      chk($sformatf("r%0d.data", k), bus.out_data,  tv[k].data);
      chk($sformatf("r%0d.ctx", k),  bus.out_ctx,   tv[k].ctx);
      chk($sformatf("r%0d.err", k),  bus.cred_err,  tv[k].err);
    end

    // Reset mid-operation drops the held entry and suppresses q_get.
    @(negedge clk);
    setin(16'hFFFF, 16'hFFFE, 16'h0, 1'b0, 16'hD001);
    #1 chk("mid.get_before", bus.q_get, 1);
    @(negedge clk);
    #1 chk("mid.held", bus.out_data, 16'hD001);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("mid.get_in_rst", bus.q_get, 0);
    @(negedge clk);
    #1 chk("mid.vld_cleared", bus.out_valid, 0);
    chk("mid.data_cleared", bus.out_data, 0);
    rst = 1'b0;

    // Credit exhaustion on context 3, then one return buys one more issue.
    do_reset();
    #1 chk("rst.vld", bus.out_valid, 0);
    chk("rst.err", bus.cred_err, 0);
    setin(16'hFFFF, 16'hFFF7, 16'h0, 1'b1, 16'hE000);
    count_issues(12, 16'h0008, cnt);
    chk("exh.count", cnt, 8);
    #1 chk("exh.starved", bus.q_get, 0);
    bus.cred_ret = 16'h0008;
    #1 chk("exh.ret_cycle", bus.q_get, 0);
    @(negedge clk);
    bus.cred_ret = 16'h0;
    #1 chk("exh.reissue", bus.q_get, 1);
    chk("exh.reissue_gctx", bus.q_gctx, 16'h0008);
    @(negedge clk);
    #1 chk("exh.starved2", bus.q_get, 0);

    // Over-return sets the sticky error and leaves the credit at its initial value.
    do_reset();
    bus.cred_ret = 16'h0001;
    @(negedge clk);
    bus.cred_ret = 16'h0;
    #1 chk("err.set", bus.cred_err, 1);
    bus.q_empty = 16'hFFFE;
    count_issues(12, 16'h0001, cnt);
    chk("err.credit_kept", cnt, 8);
    #1 chk("err.sticky", bus.cred_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("err.cleared", bus.cred_err, 0);

    // Issue and return to the same context in one cycle leave the credit unchanged.
    setin(16'hFFFF, 16'hFFFE, 16'h0001, 1'b1, 16'hF000);
    #1 chk("col.get", bus.q_get, 1);
    chk("col.gctx", bus.q_gctx, 16'h0001);
    @(negedge clk);
    bus.cred_ret = 16'h0;
    count_issues(12, 16'h0001, cnt);
    chk("col.remaining", cnt, 8);
    #1 chk("col.no_err", bus.cred_err, 0);

    // Contexts 1 and 4 contending.
    do_reset();
`ifdef MCTX_SCHED_WRR_EN
    bus.wrr_weight = '0;
    bus.wrr_weight[1*4 +: 4] = 4'd3;
    bus.wrr_weight[4*4 +: 4] = 4'd1;
    exp_order = '{1, 1, 1, 4, 1, 1, 1, 4};
`else
    exp_order = '{1, 4, 1, 4, 1, 4, 1, 4};
`endif
    setin(16'hFFFF, 16'hFFED, 16'h0, 1'b1, 16'h1234);
    for (int c = 0; c < 8; c++) begin
      #1 order[c] = bus.q_get ? oh2i(bus.q_gctx) : 99;
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) chk($sformatf("arb.order%0d", c), order[c], exp_order[c]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mctx_deq_sched.md
# mctx_deq_sched

Dequeue scheduler for the multi-context linked-list queue. Each cycle it selects at most one non-empty, enabled, credit-holding context round-robin and drives the queue's `get`/`gctx` read port. It captures the returned payload into a one-entry output register with valid/ready handshake to the downstream consumer. It also tracks per-context downstream credits so that no context overruns its consumer buffer.

## Interface

**Parameters**
- `NCTX`, default 16: number of contexts; `gctx` is one-hot of this width.
- `WIDTH`, default 16: payload width.
- `CRDW`, default 4: credit counter width.
- `CREDIT_INIT`, default 8: per-context credit value loaded at reset; must be ≤ 2^CRDW−1.

**Ports**
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ctx_en` in NCTX: per-context scheduling enable mask.
- `q_empty` in NCTX: per-context empty flags from the queue.
- `q_get` out 1: dequeue strobe to the queue.
- `q_gctx` out NCTX: one-hot context select to the queue. Zero when `q_get`=0.
- `q_dout` in WIDTH: queue read data. Combinationally valid in the same cycle as `q_get`.
- `cred_ret` in NCTX: per-context credit-return pulses, one credit each.
- `out_valid` out 1: output register holds data.
- `out_ready` in 1: consumer accepts the data.
- `out_data` out WIDTH: registered payload.
- `out_ctx` out clog2(NCTX): context index of `out_data`.
- `cred_err` out 1: sticky flag; credit overflow or illegal return.
- `wrr_weight` in NCTX*4: per-context weight. Present only with `MCTX_SCHED_WRR_EN`.

## Operation

- **Eligibility:** `elig[i] = ctx_en[i] & ~q_empty[i] & (credit[i] != 0)`.
- **Issue condition:** `issue = |elig & (~out_valid | out_ready)`. This allows at most one dequeue per cycle.
- **Arbitration:** round-robin starting at `rr_ptr`. The winner is the first eligible index at or above `rr_ptr`, wrapping modulo NCTX.
- **On issue:**
  - `q_get`=1 and `q_gctx`=one-hot(winner).
  - `q_dout` is captured into `out_data`, and the winner index into `out_ctx`.
  - `out_valid` is set at the same edge.
  - `rr_ptr` advances to winner+1, wrapping NCTX−1→0.
- **Output register states:**
  - EMPTY (`out_valid`=0) → FULL on issue.
  - FULL → EMPTY on `out_ready` with no issue.
  - FULL stays FULL on `out_ready` with an issue; the register is reloaded, giving back-to-back throughput.
  - FULL stays FULL with `out_valid`/`out_data` held stable while `out_ready`=0.
- **Credit updates, per context `i`:**
  - Issue to `i` and `cred_ret[i]` in the same cycle: `credit[i]` is unchanged.
  - Issue only: `credit[i]` decrements.
  - Return only: `credit[i]` increments.
  - A return that would push `credit[i]` above CREDIT_INIT leaves the counter unchanged and sets `cred_err`.
- **`cred_err`** clears only on `rst`.
- **Context disable:** deasserting `ctx_en[i]` affects only future arbitration. An in-flight output entry for that context is still delivered.

## Timing

- **Reset values:** `q_get`=0, `q_gctx`=0, `out_valid`=0, `out_data`=0, `out_ctx`=0, `cred_err`=0, `rr_ptr`=0, every `credit[i]`=CREDIT_INIT.
- **Assertion during operation:** `rst` asserted mid-operation discards any held output entry. No `q_get` is driven in a cycle where `rst`=1.
- **Issue latency:** `q_get` is combinational from registered state plus `q_empty`, `ctx_en` and `out_ready`. There is no internal issue latency.
- **Data latency:** from `q_get` to `out_valid` is 1 cycle.
- **Sustained rate:** one dequeue per cycle while the consumer holds `out_ready`=1.
- **Credit visibility:** a `cred_ret` pulse makes its context eligible in the next cycle.
- **Empty flag timing:** a context that just became empty is not re-selected. `q_empty` is sampled in the cycle of `q_get`, and the queue updates it by the next cycle.

## Configuration

- **`MCTX_SCHED_WRR_EN` defined:** weighted round-robin.
  - A per-grant burst counter lets the current winner be re-granted up to `wrr_weight[i]` consecutive issues before `rr_ptr` advances.
  - `rr_ptr` also advances early when the winner loses eligibility.
  - A weight of 0 is treated as 1.
  - The burst counter resets on pointer advance and on `rst`.
- **Not defined:** plain round-robin, one issue per grant. The `wrr_weight` port is absent.

## Structure

- **Shared package `mctx_pkg`:**
  - `NCTX`/`WIDTH` defaults.
  - `ctx_idx_t` (clog2(NCTX) bits).
  - `credit_t` (CRDW bits).
  - Constant `WRR_WW` = 4.
- **Sub-module `mctx_rr_arb`:** parameterised NCTX round-robin arbiter.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and grant index.
  - Combinational, instanced once.
  - Implemented as a double-width mask-and-priority scheme.
- The top level holds the credit counters, output register, pointer, burst counter and error flag.

## Test plan

- **Reset:** reset with all contexts empty → `q_get`=0, `out_valid`=0, every credit=8, `cred_err`=0.
- **Round-robin rotation:** contexts 2, 5 and 9 non-empty with `out_ready`=1 held → issue order 2, 5, 9, 2…; `out_ctx` follows one cycle later; one issue per cycle.
- **Backpressure:** `out_ready`=0 for 3 cycles with contexts non-empty → exactly one issue, then `out_data` is held stable; no further `q_get` until `out_ready`=1, then back-to-back reload.
- **Credit exhaustion:** context 3 alone, no returns → exactly 8 issues, then `q_get`=0. One `cred_ret[3]` → one more issue the following cycle.
- **Credit error and collision:**
  - `cred_ret[0]` while `credit[0]`=8 → credit stays 8 and `cred_err`=1.
  - Simultaneous issue to context 0 and `cred_ret[0]` → credit unchanged.
- **Weighted round-robin (`MCTX_SCHED_WRR_EN`):** `wrr_weight` ctx1=3 and ctx4=1, both non-empty → issue order 1, 1, 1, 4, 1, 1, 1, 4.
